// File: rtl/minimips_pc_sequencer.sv
// ----------------------------------------------------------------------------
// minimips_pc_sequencer
//
// Generates the fetch address for the MiniMIPS core. After a start command it
// steps the PC by STEP every non-stalled clock and honours branch/jump
// redirects. It stops once the instruction at LAST_PC retires.
//
// Ports
//   i_clk            : clock, all state changes on the rising edge
//   i_rst_n          : asynchronous active-low reset
//   i_start          : begin fetching from IDLE, or restart from HALT
//   i_stall          : hold the current PC this cycle
//   i_redirect       : load i_redirect_pc instead of incrementing
//   i_redirect_pc    : branch/jump target
//   o_pc             : current fetch address
//   o_pc_valid       : o_pc holds a live fetch address
//   o_halted         : LAST_PC has retired and the sequencer has stopped
//   o_retired_count  : non-stalled fetch cycles since the last start
//
// All outputs come straight from flops, so there is no input-to-output path.
// ----------------------------------------------------------------------------
module minimips_pc_sequencer #(
    parameter int unsigned           PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0]   LAST_PC  = PC_WIDTH'(29),
    parameter int unsigned           STEP     = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [PC_WIDTH-1:0] i_redirect_pc,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic                o_pc_valid,
    output logic                o_halted,
    output logic [31:0]         o_retired_count
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_pc_valid;
    logic                r_halted;
    logic [31:0]         r_retired_count;

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic                w_at_last;
    logic [31:0]         w_count_inc;

    // Increment wraps naturally at 2^PC_WIDTH.
    assign w_pc_inc    = r_pc + PC_WIDTH'(STEP);
    // Halt is decided purely by equality, so a redirect beyond LAST_PC keeps
    // running until the PC comes round to LAST_PC again.
    assign w_at_last   = (r_pc == LAST_PC);
    assign w_count_inc = r_retired_count + 32'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= StIdle;
            r_pc            <= RESET_PC;
            r_pc_valid      <= 1'b0;
            r_halted        <= 1'b0;
            r_retired_count <= 32'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state         <= StRun;
                        r_pc            <= RESET_PC;
                        r_pc_valid      <= 1'b1;
                        r_halted        <= 1'b0;
                        r_retired_count <= 32'd0;
                    end
                end

                StRun: begin
                    // Stall beats everything; a redirect seen during a stall is
                    // dropped, not queued. Halt beats a coincident redirect.
                    if (i_stall) begin
                        r_pc <= r_pc;
                    end else if (w_at_last) begin
                        r_state         <= StHalt;
                        r_pc_valid      <= 1'b0;
                        r_halted        <= 1'b1;
                        r_retired_count <= w_count_inc;
                    end else if (i_redirect) begin
                        r_pc            <= i_redirect_pc;
                        r_retired_count <= w_count_inc;
                    end else begin
                        r_pc            <= w_pc_inc;
                        r_retired_count <= w_count_inc;
                    end
                end

                StHalt: begin
                    if (i_start) begin
                        r_state         <= StRun;
                        r_pc            <= RESET_PC;
                        r_pc_valid      <= 1'b1;
                        r_halted        <= 1'b0;
                        r_retired_count <= 32'd0;
                    end
                end

                default: begin
                    r_state    <= StIdle;
                    r_pc       <= RESET_PC;
                    r_pc_valid <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc            = r_pc;
    assign o_pc_valid      = r_pc_valid;
    assign o_halted        = r_halted;
    assign o_retired_count = r_retired_count;

endmodule

// File: tb/tb_minimips_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_minimips_pc_sequencer
//
// Directed bench for the PC sequencer. Two instances share stimulus: one with
// default parameters and one configured to wrap through all-ones.
// ----------------------------------------------------------------------------
module tb_minimips_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    logic [31:0] pc, pc_w;
    logic        pc_valid, pc_valid_w;
    logic        halted, halted_w;
    logic [31:0] count, count_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    minimips_pc_sequencer dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_stall         (stall),
        .i_redirect      (redirect),
        .i_redirect_pc   (redirect_pc),
        .o_pc            (pc),
        .o_pc_valid      (pc_valid),
        .o_halted        (halted),
        .o_retired_count (count)
    );

    minimips_pc_sequencer #(
        .PC_WIDTH (32),
        .RESET_PC (32'hFFFF_FFFE),
        .LAST_PC  (32'd1),
        .STEP     (1)
    ) dut_w (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_stall         (stall),
        .i_redirect      (redirect),
        .i_redirect_pc   (redirect_pc),
        .o_pc            (pc_w),
        .o_pc_valid      (pc_valid_w),
        .o_halted        (halted_w),
        .o_retired_count (count_w)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic reset_and_start();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded advance of the default instance to a given PC.
    task automatic advance_to(input logic [31:0] target);
        int n = 0;
        while (pc !== target && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (pc !== target) begin
            failures++;
            $display("FAIL advance_to: pc=%h never reached %h", pc, target);
        end
    endtask

    task automatic run_to_halt();
        int n = 0;
        while (halted !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL run_to_halt: halted=%b after %0d edges, need 1", halted, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 32'd0 || pc_valid !== 1'b0 || halted !== 1'b0 || count !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: pc=%h v=%b h=%b cnt=%0d need 0/0/0/0",
                     pc, pc_valid, halted, count);
        end
        checks++;
        if (pc_w !== 32'hFFFF_FFFE || pc_valid_w !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_wrap: pc=%h v=%b need fffffffe/0", pc_w, pc_valid_w);
        end
        // Stall/redirect in IDLE must do nothing.
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'd7;
        tick();
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        checks++;
        if (pc !== 32'd0 || pc_valid !== 1'b0 || count !== 32'd0) begin
            failures++;
            $display("FAIL idle_ignore: pc=%h v=%b cnt=%0d need 0/0/0", pc, pc_valid, count);
        end
    endtask

    task automatic test_basic();
        reset_and_start();
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (pc !== 32'(i) || pc_valid !== 1'b1 || halted !== 1'b0) begin
                failures++;
                $display("FAIL basic_seq: pc=%h v=%b h=%b need %h/1/0", pc, pc_valid, halted, i);
            end
            tick();
        end
        checks++;
        if (halted !== 1'b1 || pc_valid !== 1'b0 || count !== 32'd30 || pc !== 32'd29) begin
            failures++;
            $display("FAIL basic_halt: h=%b v=%b cnt=%0d pc=%h need 1/0/30/1d",
                     halted, pc_valid, count, pc);
        end
    endtask

    task automatic test_stall();
        reset_and_start();
        advance_to(32'd19);
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'd5;
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        checks++;
        if (pc !== 32'd19 || pc_valid !== 1'b1 || count !== 32'd19) begin
            failures++;
            $display("FAIL stall_hold: pc=%h v=%b cnt=%0d need 13/1/19", pc, pc_valid, count);
        end
        tick();
        checks++;
        if (pc !== 32'd20) begin
            failures++;
            $display("FAIL stall_resume: pc=%h need 14", pc);
        end
        run_to_halt();
        checks++;
        if (count !== 32'd30) begin
            failures++;
            $display("FAIL stall_count: cnt=%0d need 30", count);
        end
    endtask

    task automatic test_redirect();
        reset_and_start();
        advance_to(32'd10);
        redirect = 1'b1;
        redirect_pc = 32'd3;
        tick();
        redirect = 1'b0;
        checks++;
        if (pc !== 32'd3 || count !== 32'd11) begin
            failures++;
            $display("FAIL redirect_load: pc=%h cnt=%0d need 3/11", pc, count);
        end
        tick();
        checks++;
        if (pc !== 32'd4) begin
            failures++;
            $display("FAIL redirect_next: pc=%h need 4", pc);
        end
        run_to_halt();
        // Fetches 0..10 (11) then 3..29 (27), halt edge included.
        checks++;
        if (count !== 32'd38) begin
            failures++;
            $display("FAIL redirect_count: cnt=%0d need 38", count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        exp[0] = 32'hFFFF_FFFE;
        exp[1] = 32'hFFFF_FFFF;
        exp[2] = 32'h0000_0000;
        exp[3] = 32'h0000_0001;
        reset_and_start();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_w !== exp[i] || pc_valid_w !== 1'b1) begin
                failures++;
                $display("FAIL wrap_seq: pc=%h v=%b need %h/1", pc_w, pc_valid_w, exp[i]);
            end
            tick();
        end
        checks++;
        if (halted_w !== 1'b1 || pc_valid_w !== 1'b0 || pc_w !== 32'd1 || count_w !== 32'd4) begin
            failures++;
            $display("FAIL wrap_halt: h=%b v=%b pc=%h cnt=%0d need 1/0/1/4",
                     halted_w, pc_valid_w, pc_w, count_w);
        end
    endtask

    task automatic test_halt_priority();
        reset_and_start();
        advance_to(32'd8);
        redirect = 1'b1;
        redirect_pc = 32'd29;
        tick();
        checks++;
        if (pc !== 32'd29 || halted !== 1'b0 || pc_valid !== 1'b1 || count !== 32'd9) begin
            failures++;
            $display("FAIL redirect_to_last: pc=%h h=%b v=%b cnt=%0d need 1d/0/1/9",
                     pc, halted, pc_valid, count);
        end
        redirect_pc = 32'd5;
        tick();
        redirect = 1'b0;
        checks++;
        if (halted !== 1'b1 || pc !== 32'd29 || pc_valid !== 1'b0 || count !== 32'd10) begin
            failures++;
            $display("FAIL halt_beats_redirect: h=%b pc=%h v=%b cnt=%0d need 1/1d/0/10",
                     halted, pc, pc_valid, count);
        end
    endtask

    // Runs from the HALT state left by test_halt_priority.
    task automatic test_restart();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'd7;
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        checks++;
        if (halted !== 1'b1 || pc !== 32'd29 || count !== 32'd10) begin
            failures++;
            $display("FAIL halt_ignore: h=%b pc=%h cnt=%0d need 1/1d/10", halted, pc, count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc !== 32'd0 || pc_valid !== 1'b1 || halted !== 1'b0 || count !== 32'd0) begin
            failures++;
            $display("FAIL restart: pc=%h v=%b h=%b cnt=%0d need 0/1/0/0",
                     pc, pc_valid, halted, count);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc !== 32'd2 || count !== 32'd2) begin
            failures++;
            $display("FAIL start_in_run: pc=%h cnt=%0d need 2/2", pc, count);
        end
    endtask

    task automatic test_async_reset();
        reset_and_start();
        advance_to(32'd12);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 32'd0 || pc_valid !== 1'b0 || count !== 32'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pc=%h v=%b cnt=%0d h=%b need 0/0/0/0",
                     pc, pc_valid, count, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (pc !== 32'd0 || pc_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: pc=%h v=%b need 0/0", pc, pc_valid);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc !== 32'd0 || pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_start: pc=%h v=%b need 0/1", pc, pc_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt_priority();
        test_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
